edl_ctrl_sync: RTL and testbench

- Clocked, parametrised successor to the error-detecting-latch (EDL) bundled-data stage controller.
- Replaces the fixed delay elements with cycle counters: the main delay (DELAY_B) and the error-resolution window (DELAY_E).
- Accepts a vector of NUM_EDL error flags, supports two recovery modes, and keeps a saturating error counter.
- Sits between two pipeline stages, with 4-phase req/ack handshakes on the left and right sides.

---
 rtl/edl_ctrl_pkg.sv | 23 ++
 rtl/edl_delay_cnt.sv | 30 +++
 rtl/edl_ctrl_sync.sv | 154 +++++++++++++++
 tb/tb_edl_ctrl_sync.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edl_ctrl_pkg.sv
// Shared types and helpers for the clocked EDL stage controller.
package edl_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        DELAY,
        SAMPLE,
        ERR,
        REQ
    } state_t;

    localparam int ERR_MODE_EXTEND = 0;
    localparam int ERR_MODE_REPLAY = 1;

    // Width of the shared delay counter: it must hold max(DELAY_B, DELAY_E).
    function automatic int cnt_width(input int delay_b, input int delay_e);
        int longest;
        longest = (delay_b > delay_e) ? delay_b : delay_e;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/edl_delay_cnt.sv
// Loadable down-counter used for both the main delay and the error window.
// done is high while the count is zero; the count then holds at zero.
module edl_delay_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    // Count register: load has priority over decrement.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/edl_ctrl_sync.sv
// Clocked EDL bundled-data stage controller with 4-phase handshakes on both
// sides, counter-based delays, extend/replay error recovery and a saturating
// error counter.
module edl_ctrl_sync
    import edl_ctrl_pkg::*;
#(
    parameter int NUM_EDL  = 4,
    parameter int DELAY_B  = 5,
    parameter int DELAY_E  = 5,
    parameter int ERR_MODE = 0,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               l_req,
    output logic               l_ack,
    output logic               r_req,
    input  logic               r_ack,
    input  logic [NUM_EDL-1:0] err,
    input  logic               err_clr,
    output logic               latch_en,
    output logic               sample,
    output logic               err_flag,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int CW = cnt_width(DELAY_B, DELAY_E);

    // The counter is loaded on the edge that enters LATCH (or ERR), so the
    // LATCH cycle itself is the first of the DELAY_B cycles before SAMPLE and
    // ERR lasts exactly DELAY_E cycles.
    localparam logic [CW-1:0] LOAD_B = CW'(DELAY_B - 1);
    localparam logic [CW-1:0] LOAD_E = CW'(DELAY_E - 1);

    state_t          state;
    state_t          state_nxt;
    logic            cnt_load;
    logic [CW-1:0]   cnt_load_val;
    logic            cnt_dec;
    logic            cnt_done;
    logic            err_any;
    logic            start;

    assign err_any = |err;

    // r_req is decoded from REQ, so it is always low in IDLE and needs no term here.
    assign start   = l_req && !l_ack && !r_ack;
    assign cnt_dec = (state == LATCH) || (state == DELAY) || (state == ERR);

    edl_delay_cnt #(
        .W(CW)
    ) u_delay_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .dec     (cnt_dec),
        .done    (cnt_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter loads and Moore strobes.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = LOAD_B;
        latch_en     = 1'b0;
        sample       = 1'b0;
        err_flag     = 1'b0;
        r_req        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = LATCH;
                    cnt_load     = 1'b1;
                    cnt_load_val = LOAD_B;
                end
            end
            LATCH: begin
                latch_en  = 1'b1;
                state_nxt = cnt_done ? SAMPLE : DELAY;
            end
            DELAY: begin
                if (cnt_done) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                sample = 1'b1;
                if (err_any) begin
                    state_nxt    = ERR;
                    cnt_load     = 1'b1;
                    cnt_load_val = LOAD_E;
                end else begin
                    state_nxt = REQ;
                end
            end
            ERR: begin
                err_flag = 1'b1;
                if (cnt_done) begin
                    if (ERR_MODE == ERR_MODE_REPLAY) begin
                        state_nxt    = LATCH;
                        cnt_load     = 1'b1;
                        cnt_load_val = LOAD_B;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                r_req = 1'b1;
                if (r_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Left acknowledge: raised when a token is accepted, so a replay LATCH
    // leaves it alone; dropped the cycle after l_req is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_ack <= 1'b0;
        end else if ((state == IDLE) && start) begin
            l_ack <= 1'b1;
        end else if (l_ack && !l_req) begin
            l_ack <= 1'b0;
        end
    end

    // Saturating count of erroneous samples; a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if ((state == SAMPLE) && err_any && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_edl_ctrl_sync.sv
// Bench for edl_ctrl_sync: an extend-mode instance (2-bit counter) and a
// replay-mode instance (8-bit counter) run side by side. A timestamp model
// predicts every output each cycle; directed scenarios pin timings with
// literal offsets, then a randomized phase stresses both handshakes.
module tb_edl_ctrl_sync;
    import edl_ctrl_pkg::*;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       l_req    [N];
    logic       r_ack    [N];
    logic       err_clr  [N];
    logic [3:0] err      [N];
    logic       l_ack    [N];
    logic       r_req    [N];
    logic       latch_en [N];
    logic       sample   [N];
    logic       err_flag [N];
    logic [1:0] err_cnt0;
    logic [7:0] err_cnt1;

    always #5 clk = ~clk;

    edl_ctrl_sync #(
        .NUM_EDL(4), .DELAY_B(5), .DELAY_E(5), .ERR_MODE(ERR_MODE_EXTEND), .CNT_W(2)
    ) dut0 (
        .clk(clk), .rst(rst), .l_req(l_req[0]), .l_ack(l_ack[0]), .r_req(r_req[0]),
        .r_ack(r_ack[0]), .err(err[0]), .err_clr(err_clr[0]), .latch_en(latch_en[0]),
        .sample(sample[0]), .err_flag(err_flag[0]), .err_cnt(err_cnt0)
    );

    edl_ctrl_sync #(
        .NUM_EDL(4), .DELAY_B(5), .DELAY_E(5), .ERR_MODE(ERR_MODE_REPLAY), .CNT_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .l_req(l_req[1]), .l_ack(l_ack[1]), .r_req(r_req[1]),
        .r_ack(r_ack[1]), .err(err[1]), .err_clr(err_clr[1]), .latch_en(latch_en[1]),
        .sample(sample[1]), .err_flag(err_flag[1]), .err_cnt(err_cnt1)
    );

    localparam int DB = 5;
    localparam int DE = 5;

    int n_checks = 0;
    int n_fail   = 0;
    int now      = 0;

    // Behavioural model: absolute cycle numbers of the next events per instance.
    int mode      [N];
    int cnt_max   [N];
    int latch_at  [N];
    int sample_at [N];
    int err_from  [N];
    int err_to    [N];
    int req_start [N];
    int m_cnt     [N];
    bit busy      [N];
    bit req_on    [N];
    bit m_lack    [N];

    // Environment knobs (percent chances).
    int p_lrise [N];
    int p_lfall [N];
    int p_rrise [N];
    int p_rfall [N];
    int err_pct [N];
    int clr_pct [N];
    bit clr_at_sample [N];
    logic [3:0] plan0 [$];
    logic [3:0] plan1 [$];

    // Event log of observed DUT behaviour.
    int le_t [N][8];
    int s_t  [N][8];
    int rr_t [N][8];
    int le_n [N];
    int s_n  [N];
    int rr_n [N];
    int ef_n [N];
    int la_n [N];
    bit r_req_prev [N];
    bit l_ack_prev [N];

    int exp_sat [4] = '{1, 2, 3, 3};

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", name, inst, now, act, exp);
        end
    endtask

    function automatic bit chance(input int p);
        return $urandom_range(99) < p;
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        return (i == 0) ? 32'(err_cnt0) : 32'(err_cnt1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            latch_at[i]  = -100;
            sample_at[i] = -100;
            err_from[i]  = -100;
            err_to[i]    = -100;
            req_start[i] = -100;
            m_cnt[i]     = 0;
            busy[i]      = 1'b0;
            req_on[i]    = 1'b0;
            m_lack[i]    = 1'b0;
            r_req_prev[i] = 1'b0;
            l_ack_prev[i] = 1'b0;
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < N; i++) begin
            le_n[i] = 0; s_n[i] = 0; rr_n[i] = 0; ef_n[i] = 0; la_n[i] = 0;
        end
    endtask

    // Advance the model across the clock edge that ends cycle 'now'.
    task automatic model_step(input int i);
        int t;
        bit nl_ack;
        bit nreq;
        bit nbusy;
        t      = now;
        nl_ack = m_lack[i];
        nreq   = req_on[i];
        nbusy  = busy[i];
        if (!busy[i] && l_req[i] && !m_lack[i] && !r_ack[i]) begin
            nbusy        = 1'b1;
            latch_at[i]  = t + 1;
            sample_at[i] = t + 1 + DB;
            nl_ack       = 1'b1;
        end else if (m_lack[i] && !l_req[i]) begin
            nl_ack = 1'b0;
        end
        if (t == sample_at[i]) begin
            if (err[i] != 4'd0) begin
                if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                err_from[i] = t + 1;
                err_to[i]   = t + DE;
                if (mode[i] == ERR_MODE_REPLAY) begin
                    latch_at[i]  = t + DE + 1;
                    sample_at[i] = t + DE + 1 + DB;
                end else begin
                    req_start[i] = t + DE + 1;
                end
            end else begin
                req_start[i] = t + 1;
            end
        end
        if (req_on[i] && r_ack[i]) begin
            nreq  = 1'b0;
            nbusy = 1'b0;
        end
        if (t + 1 == req_start[i]) nreq = 1'b1;
        if (err_clr[i]) m_cnt[i] = 0;
        m_lack[i] = nl_ack;
        req_on[i] = nreq;
        busy[i]   = nbusy;
    endtask

    task automatic compare_outputs();
        for (int i = 0; i < N; i++) begin
            check("latch_en", i, latch_en[i], now == latch_at[i]);
            check("sample",   i, sample[i],   now == sample_at[i]);
            check("err_flag", i, err_flag[i], (now >= err_from[i]) && (now <= err_to[i]));
            check("r_req",    i, r_req[i],    req_on[i]);
            check("l_ack",    i, l_ack[i],    m_lack[i]);
            check("err_cnt",  i, cnt_of(i),   m_cnt[i]);
            if (latch_en[i] === 1'b1) begin
                if (le_n[i] < 8) le_t[i][le_n[i]] = now;
                le_n[i]++;
            end
            if (sample[i] === 1'b1) begin
                if (s_n[i] < 8) s_t[i][s_n[i]] = now;
                s_n[i]++;
            end
            if (r_req[i] === 1'b1 && !r_req_prev[i]) begin
                if (rr_n[i] < 8) rr_t[i][rr_n[i]] = now;
                rr_n[i]++;
            end
            if (err_flag[i] === 1'b1) ef_n[i]++;
            if (l_ack[i] === 1'b1 && !l_ack_prev[i]) la_n[i]++;
            r_req_prev[i] = (r_req[i] === 1'b1);
            l_ack_prev[i] = (l_ack[i] === 1'b1);
        end
    endtask

    task automatic tick();
        for (int i = 0; i < N; i++) model_step(i);
        @(negedge clk);
        now++;
        compare_outputs();
    endtask

    task automatic next_err(input int i, output logic [3:0] v);
        if (i == 0 && plan0.size() > 0) v = plan0.pop_front();
        else if (i == 1 && plan1.size() > 0) v = plan1.pop_front();
        else if (chance(err_pct[i])) v = 4'($urandom_range(15, 1));
        else v = 4'd0;
    endtask

    // Protocol-respecting environment; junk on err outside SAMPLE must be ignored.
    task automatic drive();
        logic [3:0] v;
        for (int i = 0; i < N; i++) begin
            if (!l_req[i] && !l_ack[i] && chance(p_lrise[i])) l_req[i] = 1'b1;
            else if (l_req[i] && l_ack[i] && chance(p_lfall[i])) l_req[i] = 1'b0;
            if (r_req[i] && !r_ack[i] && chance(p_rrise[i])) r_ack[i] = 1'b1;
            else if (r_ack[i] && !r_req[i] && chance(p_rfall[i])) r_ack[i] = 1'b0;
            if (now == sample_at[i]) begin
                next_err(i, v);
                err[i] = v;
            end else begin
                err[i] = 4'($urandom_range(15));
            end
            err_clr[i] = (clr_at_sample[i] && now == sample_at[i]) || chance(clr_pct[i]);
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = 1'b1;
        for (int i = 0; i < N; i++)
            if (busy[i] || l_req[i] || l_ack[i] || r_req[i] || r_ack[i]) q = 1'b0;
        return q;
    endfunction

    task automatic wait_quiet(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            drive();
            tick();
            done = quiet();
        end
        check("quiet_timeout", 0, done, 1);
    endtask

    task automatic set_direct(input int i);
        p_lrise[i] = 0; p_lfall[i] = 100; p_rrise[i] = 100; p_rfall[i] = 100;
        err_pct[i] = 0; clr_pct[i] = 0; clr_at_sample[i] = 1'b0;
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < N; i++) begin
            check("rst_l_ack",    i, l_ack[i],    0);
            check("rst_r_req",    i, r_req[i],    0);
            check("rst_latch_en", i, latch_en[i], 0);
            check("rst_sample",   i, sample[i],   0);
            check("rst_err_flag", i, err_flag[i], 0);
            check("rst_err_cnt",  i, cnt_of(i),   0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            l_req[i] = 1'b0; r_ack[i] = 1'b0; err_clr[i] = 1'b0; err[i] = 4'd0;
        end
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One error-free token on instance 0 with literal timing expectations.
    task automatic plain_token_inst0();
        clear_log();
        l_req[0] = 1'b1;
        wait_quiet(60);
        check("t1_le_count",     0, le_n[0], 1);
        check("t1_sample_delay", 0, s_t[0][0] - le_t[0][0], 5);
        check("t1_rreq_delay",   0, rr_t[0][0] - le_t[0][0], 6);
        check("t1_err_flag",     0, ef_n[0], 0);
        check("t1_err_cnt",      0, cnt_of(0), 0);
    endtask

    initial begin
        bit in_delay;
        int drop_cycle;
        mode[0] = ERR_MODE_EXTEND; cnt_max[0] = 3;
        mode[1] = ERR_MODE_REPLAY; cnt_max[1] = 255;
        for (int i = 0; i < N; i++) set_direct(i);
        clear_log();
        apply_reset();

        // Test 1: no error, immediate right acknowledge.
        plain_token_inst0();

        // Test 2: extend mode, single error bit.
        clear_log();
        plan0.push_back(4'b0100);
        l_req[0] = 1'b1;
        wait_quiet(60);
        check("t2_err_flag_len", 0, ef_n[0], 5);
        check("t2_rreq_delay",   0, rr_t[0][0] - le_t[0][0], 11);
        check("t2_err_cnt",      0, cnt_of(0), 1);

        // Test 3: replay mode, error then clean replay.
        clear_log();
        plan1.push_back(4'b1001);
        plan1.push_back(4'b0000);
        l_req[1] = 1'b1;
        wait_quiet(80);
        check("t3_le_count",   1, le_n[1], 2);
        check("t3_replay_gap", 1, le_t[1][1] - le_t[1][0], 11);
        check("t3_l_ack_once", 1, la_n[1], 1);
        check("t3_err_cnt",    1, cnt_of(1), 1);
        check("t3_s_count",    1, s_n[1], 2);
        check("t3_rreq_after", 1, rr_t[1][0] - s_t[1][1], 1);

        // Test 4: right side stays busy while the next request arrives.
        p_rfall[0] = 0;
        p_lrise[0] = 100;
        l_req[0]   = 1'b1;
        for (int c = 0; c < 25; c++) begin drive(); tick(); end
        p_lrise[0] = 0;
        clear_log();
        for (int c = 0; c < 10; c++) begin drive(); tick(); end
        check("t4_no_latch_busy", 0, le_n[0], 0);
        check("t4_r_ack_held",    0, r_ack[0], 1);
        r_ack[0]   = 1'b0;
        drop_cycle = now;
        p_rfall[0] = 100;
        wait_quiet(60);
        // r_ack low is first seen at the edge ending drop_cycle, so LATCH follows directly.
        check("t4_latch_after_drop", 0, le_t[0][0] - drop_cycle, 1);

        // Test 5: saturation of the 2-bit counter and clear-wins.
        clr_pct[0] = 100;
        drive(); tick();
        clr_pct[0] = 0;
        check("t5_cleared", 0, cnt_of(0), 0);
        for (int k = 0; k < 4; k++) begin
            plan0.push_back((k == 0) ? 4'hF : (k == 1) ? 4'h2 : (k == 2) ? 4'h8 : 4'h3);
            l_req[0] = 1'b1;
            wait_quiet(60);
            check("t5_sat_count", 0, cnt_of(0), exp_sat[k]);
        end
        plan0.push_back(4'h1);
        clr_at_sample[0] = 1'b1;
        l_req[0] = 1'b1;
        wait_quiet(60);
        clr_at_sample[0] = 1'b0;
        check("t5_clear_wins", 0, cnt_of(0), 0);

        // Test 6: asynchronous reset in DELAY, then a fresh token.
        l_req[0] = 1'b1;
        in_delay = 1'b0;
        for (int c = 0; c < 20 && !in_delay; c++) begin
            drive();
            tick();
            in_delay = (now > latch_at[0]) && (now < sample_at[0]);
        end
        check("t6_reached_delay", 0, in_delay, 1);
        #2;
        apply_reset();
        plain_token_inst0();

        // Randomized phase on both instances.
        for (int i = 0; i < N; i++) begin
            p_lrise[i] = 40; p_lfall[i] = 50; p_rrise[i] = 40; p_rfall[i] = 50;
            err_pct[i] = 30; clr_pct[i] = 2;
        end
        for (int c = 0; c < 3000; c++) begin drive(); tick(); end
        for (int i = 0; i < N; i++) begin
            p_lrise[i] = 0; p_lfall[i] = 100; p_rrise[i] = 100; p_rfall[i] = 100;
            err_pct[i] = 0; clr_pct[i] = 0;
        end
        wait_quiet(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
